// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_pkg
//  Description : Shared constants, class-bit indices and FSM state encoding
//                for the single-precision FP unpack front end.
//  Revision    : 1.0  initial release
// ============================================================================
package fp_pkg;

    // Field widths of an IEEE 754 single-precision operand
    localparam int FRAC_W   = 23;
    localparam int EXP_W    = 8;
    // Unpacked exponent is two bits wider so normalized subnormals can go below 1
    localparam int EXPO_W   = EXP_W + 2;
    localparam int OP_W     = 1 + EXP_W + FRAC_W;
    localparam int MANT_W   = FRAC_W + 1;

    localparam int EXP_BIAS = 127;
    localparam int EXP_MAX  = 255;

    // Class vector layout: {nan, snan, inf, zero, sub}
    localparam int CLS_W    = 5;
    localparam int CLS_NAN  = 4;
    localparam int CLS_SNAN = 3;
    localparam int CLS_INF  = 2;
    localparam int CLS_ZERO = 1;
    localparam int CLS_SUB  = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/fp_unpack_lane.sv
`default_nettype none
// ============================================================================
//  Module      : fp_unpack_lane
//  Description : One operand lane: decodes sign/exponent/mantissa/class from
//                an IEEE 754 single, holds the result, and performs one
//                normalization step (shift left, exponent minus one) per
//                cycle on request while the mantissa is still subnormal.
//  Revision    : 1.0  initial release
// ============================================================================
module fp_unpack_lane
    import fp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_step,
    input  logic [OP_W-1:0]   i_op,
    output logic              o_dec_sub,
    output logic              o_norm_done,
    output logic              o_done_next,
    output logic              o_sign,
    output logic [EXPO_W-1:0] o_exp,
    output logic [MANT_W-1:0] o_mant,
    output logic [CLS_W-1:0]  o_cls
);

    logic [EXP_W-1:0]  w_e;
    logic [FRAC_W-1:0] w_f;
    logic [EXPO_W-1:0] w_exp;
    logic [MANT_W-1:0] w_mant;
    logic [CLS_W-1:0]  w_cls;

    logic              r_sign;
    logic [EXPO_W-1:0] r_exp;
    logic [MANT_W-1:0] r_mant;
    logic [CLS_W-1:0]  r_cls;

    assign w_e = i_op[FRAC_W +: EXP_W];
    assign w_f = i_op[FRAC_W-1:0];

    // Subnormal at decode time: the FSM uses this to choose NORM over HOLD
    assign o_dec_sub = (w_e == '0) && (w_f != '0);

    // Decode the raw operand into exponent, mantissa and class
    always_comb begin
        w_exp  = EXPO_W'(w_e);
        w_mant = {1'b1, w_f};
        w_cls  = '0;
        if (w_e == EXP_W'(EXP_MAX)) begin
            if (w_f == '0) begin
                w_cls[CLS_INF] = 1'b1;
            end else begin
                w_cls[CLS_NAN]  = 1'b1;
                w_cls[CLS_SNAN] = ~w_f[FRAC_W-1];
            end
        end else if (w_e == '0) begin
            if (w_f == '0) begin
                w_cls[CLS_ZERO] = 1'b1;
                w_exp           = '0;
                w_mant          = '0;
            end else begin
                // Subnormals behave as exponent 1 with no hidden bit
                w_cls[CLS_SUB] = 1'b1;
                w_exp          = EXPO_W'(1);
                w_mant         = {1'b0, w_f};
            end
        end
    end

    // A lane is settled when it is not subnormal or its leading 1 is in place;
    // done_next looks one shift ahead so the FSM can leave NORM on the last step
    assign o_norm_done = ~r_cls[CLS_SUB] | r_mant[MANT_W-1];
    assign o_done_next = o_norm_done | r_mant[MANT_W-2];

    // Load a freshly decoded operand, or apply one normalization step
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sign <= 1'b0;
            r_exp  <= '0;
            r_mant <= '0;
            r_cls  <= '0;
        end else if (i_load) begin
            r_sign <= i_op[OP_W-1];
            r_exp  <= w_exp;
            r_mant <= w_mant;
            r_cls  <= w_cls;
        end else if (i_step && !o_norm_done) begin
            r_mant <= {r_mant[MANT_W-2:0], 1'b0};
            r_exp  <= r_exp - EXPO_W'(1);
        end
    end

    assign o_sign = r_sign;
    assign o_exp  = r_exp;
    assign o_mant = r_mant;
    assign o_cls  = r_cls;

endmodule
`default_nettype wire

// File: rtl/fp_unpack.sv
`default_nettype none
// ============================================================================
//  Module      : fp_unpack
//  Description : FP divide/multiply front end. Accepts an operand pair over a
//                valid/ready handshake, unpacks both operands, normalizes any
//                subnormal one bit per cycle, and presents the pair until the
//                downstream stage accepts it.
//  Revision    : 1.0  initial release
// ============================================================================
module fp_unpack
    import fp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   a_in,
    input  logic [OP_W-1:0]   b_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              a_sign,
    output logic              b_sign,
    output logic [EXPO_W-1:0] a_exp,
    output logic [EXPO_W-1:0] b_exp,
    output logic [MANT_W-1:0] a_mant,
    output logic [MANT_W-1:0] b_mant,
    output logic [CLS_W-1:0]  a_class,
    output logic [CLS_W-1:0]  b_class
);

    state_t r_state;
    state_t w_state_nxt;

    logic w_load;
    logic w_step;
    logic w_a_dec_sub, w_b_dec_sub;
    logic w_a_done, w_b_done;
    logic w_a_done_next, w_b_done_next;
    logic w_any_sub;

    fp_unpack_lane u_lane_a (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_step      (w_step),
        .i_op        (a_in),
        .o_dec_sub   (w_a_dec_sub),
        .o_norm_done (w_a_done),
        .o_done_next (w_a_done_next),
        .o_sign      (a_sign),
        .o_exp       (a_exp),
        .o_mant      (a_mant),
        .o_cls       (a_class)
    );

    fp_unpack_lane u_lane_b (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_step      (w_step),
        .i_op        (b_in),
        .o_dec_sub   (w_b_dec_sub),
        .o_norm_done (w_b_done),
        .o_done_next (w_b_done_next),
        .o_sign      (b_sign),
        .o_exp       (b_exp),
        .o_mant      (b_mant),
        .o_cls       (b_class)
    );

    assign w_any_sub = w_a_dec_sub | w_b_dec_sub;
    assign out_valid = (r_state == HOLD);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, handshake and lane control
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        w_load      = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = w_any_sub ? NORM : HOLD;
                end
            end
            NORM: begin
                // Lanes that are already settled ignore the step
                w_step = 1'b1;
                if (w_a_done_next && w_b_done_next) begin
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                // Pass-through ready lets a new pair in on the same edge
                in_ready = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        w_load      = 1'b1;
                        w_state_nxt = w_any_sub ? NORM : HOLD;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_unpack.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_unpack
//  Description : Self-checking bench for fp_unpack with a reference decoder
//                and an expected-result queue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fp_unpack;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a_in, b_in;
    logic        out_valid;
    logic        out_ready;
    logic        a_sign, b_sign;
    logic [9:0]  a_exp, b_exp;
    logic [23:0] a_mant, b_mant;
    logic [4:0]  a_class, b_class;

    fp_unpack dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a_sign    (a_sign),
        .b_sign    (b_sign),
        .a_exp     (a_exp),
        .b_exp     (b_exp),
        .a_mant    (a_mant),
        .b_mant    (b_mant),
        .a_class   (a_class),
        .b_class   (b_class)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sign;
        logic [9:0]  exp;
        logic [23:0] mant;
        logic [4:0]  cls;
        int          sh;
    } lane_t;

    typedef struct {
        lane_t a;
        lane_t b;
        bit    chk_lat;
        int    acc;
    } entry_t;

    entry_t sb[$];
    int     cyc = 0;
    int     n_chk = 0;
    int     n_pass = 0;
    int     n_out = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference decoder: subnormals normalized by locating the top set bit
    function automatic lane_t model(input logic [31:0] x);
        lane_t       r;
        logic [7:0]  e;
        logic [22:0] f;
        int          p;
        e      = x[30:23];
        f      = x[22:0];
        r.sign = x[31];
        r.sh   = 0;
        r.cls  = 5'b00000;
        if (e == 8'hFF) begin
            r.exp  = 10'd255;
            r.mant = {1'b1, f};
            r.cls  = (f == 23'd0) ? 5'b00100 : {1'b1, ~f[22], 3'b000};
        end else if (e == 8'h00) begin
            if (f == 23'd0) begin
                r.exp  = 10'd0;
                r.mant = 24'd0;
                r.cls  = 5'b00010;
            end else begin
                p = 0;
                for (int i = 0; i < 23; i++) if (f[i]) p = i;
                r.sh   = 23 - p;
                r.mant = {1'b0, f} << r.sh;
                r.exp  = 10'(1 - r.sh);
                r.cls  = 5'b00001;
            end
        end else begin
            r.exp  = {2'b00, e};
            r.mant = {1'b1, f};
        end
        return r;
    endfunction

    function automatic logic [31:0] gen_op();
        logic [31:0] v;
        logic [22:0] f;
        f = 23'($urandom);
        case ($urandom_range(0, 4))
            0: v = {1'b0, 8'($urandom_range(1, 254)), f};
            1: begin
                f = f >> $urandom_range(0, 22);
                if (f == 23'd0) f = 23'd1;
                v = {1'b0, 8'h00, f};
            end
            2: v = 32'h0;
            3: v = 32'h7F800000;
            default: v = {1'b0, 8'hFF, (f == 23'd0) ? 23'd5 : f};
        endcase
        v[31] = 1'($urandom);
        return v;
    endfunction

    // Drive a pair starting #1 after a rising edge; returns #1 after the accepting edge
    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input bit push, input bit chk_lat, output int waits);
        entry_t e;
        bit     acc;
        in_valid = 1'b1;
        a_in     = a;
        b_in     = b;
        waits    = 0;
        acc      = 1'b0;
        while (!acc && waits < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (!acc) waits++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            check("accept_timeout", 64'(waits), 64'd0);
        end else if (push) begin
            e.a       = model(a);
            e.b       = model(b);
            e.chk_lat = chk_lat;
            e.acc     = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic cmp_outputs(input string pfx, input entry_t e);
        check({pfx, "_a_sign"}, 64'(a_sign),  64'(e.a.sign));
        check({pfx, "_a_exp"},  64'(a_exp),   64'(e.a.exp));
        check({pfx, "_a_mant"}, 64'(a_mant),  64'(e.a.mant));
        check({pfx, "_a_cls"},  64'(a_class), 64'(e.a.cls));
        check({pfx, "_b_sign"}, 64'(b_sign),  64'(e.b.sign));
        check({pfx, "_b_exp"},  64'(b_exp),   64'(e.b.exp));
        check({pfx, "_b_mant"}, 64'(b_mant),  64'(e.b.mant));
        check({pfx, "_b_cls"},  64'(b_class), 64'(e.b.cls));
    endtask

    // Output monitor: pop and compare on every completed output handshake
    always @(negedge clk) begin
        entry_t e;
        int     lat;
        int     exp_lat;
        if (!rst && out_valid && out_ready) begin
            n_out++;
            if (sb.size() == 0) begin
                check("spurious_out", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                cmp_outputs("out", e);
                if (e.chk_lat) begin
                    lat     = cyc - e.acc + 1;
                    exp_lat = 1 + ((e.a.sh > e.b.sh) ? e.a.sh : e.b.sh);
                    check("latency", 64'(lat), 64'(exp_lat));
                end
            end
        end
    end

    initial begin
        int w;
        int n;
        int n_out_snap;
        entry_t e;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a_in      = 32'h0;
        b_in      = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_a_exp",     64'(a_exp),     64'd0);
        check("rst_b_mant",    64'(b_mant),    64'd0);
        check("rst_a_class",   64'(a_class),   64'd0);

        // Normal operands, subnormal extremes, NaNs, zero/inf
        send(32'h3F800000, 32'hC0000000, 1, 1, w); drain();
        send(32'h00000001, 32'h00400000, 1, 1, w); drain();
        send(32'h7FC00000, 32'h7F800001, 1, 1, w); drain();
        send(32'h80000000, 32'h7F800000, 1, 1, w); drain();

        // Back-to-back throughput with out_ready held high
        send(32'h3F800000, 32'h40000000, 1, 1, w);
        check("b2b_wait0", 64'(w), 64'd0);
        send(32'h41200000, 32'hBF000000, 1, 1, w);
        check("b2b_wait1", 64'(w), 64'd0);
        send(32'h7F7FFFFF, 32'h00800000, 1, 1, w);
        check("b2b_wait2", 64'(w), 64'd0);
        send(32'h12345678, 32'h87654321, 1, 1, w);
        check("b2b_wait3", 64'(w), 64'd0);
        drain();

        // Back-pressure: outputs held stable and in_ready low while stalled
        out_ready = 1'b0;
        send(32'h40490FDB, 32'h00000010, 1, 0, w);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("bp_out_valid", 64'(out_valid), 64'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            e = sb[0];
            cmp_outputs("hold", e);
            check("hold_in_ready",  64'(in_ready),  64'd0);
            check("hold_out_valid", 64'(out_valid), 64'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(32'h3F800000, 32'hBF800000, 1, 1, w);
        check("bp_same_cycle_accept", 64'(w), 64'd0);
        drain();

        // Random mix
        for (int k = 0; k < 16; k++) begin
            send(gen_op(), gen_op(), 1, 1, w);
        end
        drain();

        // Reset during normalization discards the pair
        n_out_snap = n_out;
        send(32'h00000001, 32'h3F800000, 0, 0, w);
        repeat (10) @(posedge clk);
        #1;
        check("midnorm_busy", 64'(in_ready), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midnorm_out_valid", 64'(out_valid), 64'd0);
        check("midnorm_in_ready",  64'(in_ready),  64'd1);
        check("midnorm_a_mant",    64'(a_mant),    64'd0);
        check("midnorm_a_class",   64'(a_class),   64'd0);
        repeat (30) @(posedge clk);
        #1;
        check("midnorm_no_output", 64'(n_out - n_out_snap), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
